wb_mic_dma: RTL and testbench

Wishbone initiator that turns the 1-bit `mic` input into pulse-density level samples and writes them into a circular buffer in SoC memory without CPU involvement. It sits on the LM32 data bus as a bus master, next to the memory-mapped mic peripherals. It converts `mic` to 16-bit samples, buffers them in a small word FIFO, and issues single-beat Wishbone write cycles to `buf_base`. It flags wrap-around and sample loss to the CPU via status outputs.

---
 rtl/wb_mic_dma.sv | 255 +++++++++++++++++++++++++
 tb/tb_wb_mic_dma.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mic_dma.sv
// wb_mic_dma
// ----------
// Wishbone write-only initiator that turns the 1-bit microphone stream into
// pulse-density level samples. Each sample is the count of high cycles over a
// window of DIV clocks. Finished words are queued in a small FIFO and written
// with single-beat Wishbone cycles into a circular buffer starting at buf_base.
//
// Parameters
//   DIV          sample window length in clk cycles (2..65535)
//   FIFO_DEPTH   word FIFO entries (power of two, 2..16)
//
// Ports
//   clk, reset_n           system clock, asynchronous active-low reset
//   mic                    asynchronous microphone bit
//   enable                 capture enable (level)
//   buf_base, buf_words    circular buffer byte base and length in words
//   wb_cyc_o .. wb_dat_o   Wishbone master write channel
//   wb_ack_i               Wishbone acknowledge
//   wrap_o                 one-cycle pulse after the write offset wraps to 0
//   overflow_o             sticky: a word was dropped (cleared while disabled)
//   busy_o                 bus cycle open or FIFO non-empty
//
// Build option
//   WB_MIC_DMA_PACK_EN     when defined, two samples are packed per word
//                          ({second, first}); otherwise word = {16'h0, sample}.

module wb_mic_dma #(
    parameter int DIV        = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mic,
    input  logic        enable,
    input  logic [31:0] buf_base,
    input  logic [15:0] buf_words,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    output logic        wrap_o,
    output logic        overflow_o,
    output logic        busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state;

    // Byte lane bits of the base address are not used
    logic unused_base_bits;
    assign unused_base_bits = &{1'b0, buf_base[1:0]};

    // Two-flop synchronizer for the asynchronous microphone bit
    logic mic_meta;
    logic mic_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mic_meta <= 1'b0;
            mic_sync <= 1'b0;
        end else begin
            mic_meta <= mic;
            mic_sync <= mic_meta;
        end
    end

    // Sampler: the sample includes the last cycle of the window, so the
    // running count is added to the current synced bit before saturating.
    logic [15:0] win_cnt;
    logic [16:0] high_cnt;
    logic [16:0] high_total;
    logic [15:0] sample;
    logic        win_end;

    assign win_end    = enable && (win_cnt == 16'(DIV - 1));
    assign high_total = high_cnt + {16'd0, mic_sync};
    assign sample     = high_total[16] ? 16'hFFFF : high_total[15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt  <= '0;
            high_cnt <= '0;
        end else if (!enable || win_end) begin
            win_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + 16'd1;
            high_cnt <= high_total;
        end
    end

    // Word formation
    logic        push_req;
    logic [31:0] push_word;

`ifdef WB_MIC_DMA_PACK_EN
    logic [15:0] stage;
    logic        stage_full;

    // First sample of a pair waits in the staging register; a half-filled
    // pair is discarded when capture stops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage      <= '0;
            stage_full <= 1'b0;
        end else if (!enable) begin
            stage_full <= 1'b0;
        end else if (win_end) begin
            if (stage_full) begin
                stage_full <= 1'b0;
            end else begin
                stage      <= sample;
                stage_full <= 1'b1;
            end
        end
    end

    assign push_req  = win_end && stage_full;
    assign push_word = {sample, stage};
`else
    assign push_req  = win_end;
    assign push_word = {16'h0000, sample};
`endif

    // FIFO control. The head word is dequeued into wb_dat_o when a bus cycle
    // launches, so the in-flight word no longer occupies a slot and all
    // FIFO_DEPTH entries hold words still waiting for the bus.
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             launch;
    logic             push_ok;
    logic             flush;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign launch     = (state == IDLE) && enable && !fifo_empty && (buf_words != 16'd0);
    assign push_ok    = push_req && (!fifo_full || launch);
    // Flushing waits until any open bus cycle has completed
    assign flush      = (state == IDLE) && !enable;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, launch})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky drop flag, held clear while capture is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o <= 1'b0;
        end else if (!enable) begin
            overflow_o <= 1'b0;
        end else if (push_req && fifo_full && !launch) begin
            overflow_o <= 1'b1;
        end
    end

    // Offset advance: comparing offset+1 against buf_words also wraps an
    // offset left out of range by a shrinking buf_words.
    logic [15:0] offset;
    logic [16:0] next_off;
    logic        off_wrap;

    assign next_off = {1'b0, offset} + 17'd1;
    assign off_wrap = (next_off >= {1'b0, buf_words});

    // Master FSM with registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            offset   <= '0;
            wrap_o   <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        offset <= '0;
                    end else if (launch) begin
                        state    <= WRITE;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= {buf_base[31:2] + {14'd0, offset}, 2'b00};
                        wb_dat_o <= fifo_mem[rd_ptr];
                    end
                end
                WRITE: begin
                    if (wb_ack_i) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'h0;
                        if (off_wrap) begin
                            offset <= '0;
                            wrap_o <= 1'b1;
                        end else begin
                            offset <= next_off[15:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = wb_cyc_o || !fifo_empty;

endmodule

// File: tb/tb_wb_mic_dma.sv
// tb_wb_mic_dma
// -------------
// Self-checking bench for wb_mic_dma with DIV=16 and FIFO_DEPTH=4. A monitor
// records every acknowledged write; each scenario task queues the writes it
// expects and compares them against the recorded ones. Works with or without
// WB_MIC_DMA_PACK_EN defined.

module tb_wb_mic_dma;

    localparam int D     = 16;
    localparam int DEPTH = 4;
`ifdef WB_MIC_DMA_PACK_EN
    localparam int SPW = 2;
`else
    localparam int SPW = 1;
`endif

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mic;
    logic        enable;
    logic [31:0] buf_base;
    logic [15:0] buf_words;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wrap_o;
    logic        overflow_o;
    logic        busy_o;
    logic        ack_allow;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   wrap_q[$];

    int total        = 0;
    int bad          = 0;
    int cyc_cnt      = 0;
    int wr_total     = 0;
    int last_ack_cyc = 0;
    int unstable_cnt = 0;

    logic        prev_open = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [68:0] prev_bus  = '0;

    wb_mic_dma #(
        .DIV        (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mic        (mic),
        .enable     (enable),
        .buf_base   (buf_base),
        .buf_words  (buf_words),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_i   (wb_ack_i),
        .wrap_o     (wrap_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    // Zero-wait slave whose acknowledge can be withheld
    assign wb_ack_i = ack_allow && wb_cyc_o && wb_stb_o;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Bus monitor, sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        obs_t o;
        if (reset_n) begin
            if (wb_cyc_o && wb_stb_o && prev_open && !prev_ack &&
                ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== prev_bus)) begin
                unstable_cnt = unstable_cnt + 1;
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                o.adr = wb_adr_o;
                o.dat = wb_dat_o;
                o.we  = wb_we_o;
                o.sel = wb_sel_o;
                o.cyc = cyc_cnt;
                obs_q.push_back(o);
                wr_total     = wr_total + 1;
                last_ack_cyc = cyc_cnt;
            end
            if (wrap_o) begin
                wrap_q.push_back(wr_total * 100 + (cyc_cnt - last_ack_cyc));
            end
        end
        prev_open = wb_cyc_o && wb_stb_o;
        prev_ack  = wb_ack_i;
        prev_bus  = {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o};
    end

    function automatic logic [31:0] word_of(input logic [15:0] s);
`ifdef WB_MIC_DMA_PACK_EN
        return {s, s};
`else
        return {16'h0000, s};
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1 mic = ~mic;
        end
    endtask

    task automatic expect_writes(input logic [31:0] base, input int n,
                                 input int first_off, input int words, input logic [31:0] dat);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.adr = {base[31:2], 2'b00} + 32'(((first_off + i) % words) * 4);
            e.dat = dat;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(2);
        total++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
        end
        total++;
        if ({wb_adr_o, wb_dat_o} !== 64'd0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=0", {wb_adr_o, wb_dat_o});
        end
        total++;
        if ({wrap_o, overflow_o, busy_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_status got=%b want=000", {wrap_o, overflow_o, busy_o});
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_mic_high;
        exp_t e;
        obs_t o;
        int   prev_cyc;
        mic       = 1'b1;
        buf_base  = 32'h0000_1000;
        buf_words = 16'd8;
        ack_allow = 1'b1;
        tick(4);
        expect_writes(32'h1000, 5, 0, 8, word_of(16'(D)));
        enable = 1'b1;
        tick(5 * SPW * D + 4);
        enable = 1'b0;
        tick(4);
        total++;
        if (obs_q.size() != 5) begin
            bad++;
            $display("[TB] FAIL high_count got=%0d want=5", obs_q.size());
        end
        prev_cyc = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL high_missing got=none want=%h@%h", e.dat, e.adr);
            end else begin
                o = obs_q.pop_front();
                if ({o.we, o.sel, o.adr, o.dat} !== {1'b1, 4'hF, e.adr, e.dat}) begin
                    bad++;
                    $display("[TB] FAIL high_write got=%b/%h %h@%h want=1/f %h@%h",
                             o.we, o.sel, o.dat, o.adr, e.dat, e.adr);
                end
                if (prev_cyc >= 0) begin
                    total++;
                    if (o.cyc - prev_cyc != SPW * D) begin
                        bad++;
                        $display("[TB] FAIL high_spacing got=%0d want=%0d", o.cyc - prev_cyc, SPW * D);
                    end
                end
                prev_cyc = o.cyc;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_patterns;
        exp_t e;
        obs_t o;
        buf_base  = 32'h0000_2003;
        buf_words = 16'd8;
        mic       = 1'b0;
        toggle_cycles(4);
        enable = 1'b1;
        expect_writes(32'h2000, 3, 0, 8, word_of(16'(D / 2)));
        toggle_cycles(3 * SPW * D + 4);
        enable = 1'b0;
        toggle_cycles(2);
        mic = 1'b0;
        tick(4);
        expect_writes(32'h2000, 2, 0, 8, word_of(16'h0000));
        enable = 1'b1;
        tick(2 * SPW * D + 4);
        enable = 1'b0;
        tick(4);
        total++;
        if (obs_q.size() != 5) begin
            bad++;
            $display("[TB] FAIL pattern_count got=%0d want=5", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL pattern_missing got=none want=%h@%h", e.dat, e.adr);
            end else begin
                o = obs_q.pop_front();
                if ({o.we, o.sel, o.adr, o.dat} !== {1'b1, 4'hF, e.adr, e.dat}) begin
                    bad++;
                    $display("[TB] FAIL pattern_write got=%h@%h want=%h@%h", o.dat, o.adr, e.dat, e.adr);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_wrap;
        exp_t e;
        obs_t o;
        int   base_total;
        mic       = 1'b1;
        buf_base  = 32'h0000_1000;
        buf_words = 16'd3;
        wrap_q.delete();
        tick(4);
        base_total = wr_total;
        expect_writes(32'h1000, 4, 0, 3, word_of(16'(D)));
        enable = 1'b1;
        tick(4 * SPW * D + 4);
        enable = 1'b0;
        tick(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL wrap_missing got=none want=%h@%h", e.dat, e.adr);
            end else begin
                o = obs_q.pop_front();
                if ({o.adr, o.dat} !== {e.adr, e.dat}) begin
                    bad++;
                    $display("[TB] FAIL wrap_write got=%h@%h want=%h@%h", o.dat, o.adr, e.dat, e.adr);
                end
            end
        end
        total++;
        if (wrap_q.size() != 1 || wrap_q[0] != (base_total + 3) * 100 + 1) begin
            bad++;
            $display("[TB] FAIL wrap_pulse got=%0d pulses first=%0d want=1 pulse %0d",
                     wrap_q.size(), (wrap_q.size() > 0) ? wrap_q[0] : -1, (base_total + 3) * 100 + 1);
        end
        obs_q.delete();
        // A zero-length buffer queues samples but never touches the bus
        buf_words = 16'd0;
        enable = 1'b1;
        tick(2 * SPW * D + 2);
        total++;
        if (obs_q.size() != 0 || busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_words got=%0d writes busy=%b want=0 writes busy=1", obs_q.size(), busy_o);
        end
        enable = 1'b0;
        tick(2);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_flush got=%b want=0", busy_o);
        end
        obs_q.delete();
        buf_words = 16'd8;
    endtask

    task automatic test_overflow;
        exp_t e;
        obs_t o;
        int   unstable_start;
        mic       = 1'b1;
        buf_base  = 32'h0000_1000;
        buf_words = 16'd8;
        ack_allow = 1'b0;
        tick(4);
        unstable_start = unstable_cnt;
        expect_writes(32'h1000, 5, 0, 8, word_of(16'(D)));
        enable = 1'b1;
        tick(6 * SPW * D - 1);
        total++;
        if (overflow_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_early got=%b want=0", overflow_o);
        end
        tick(1);
        total++;
        if (overflow_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_set got=%b want=1", overflow_o);
        end
        total++;
        if ({wb_cyc_o, wb_stb_o, busy_o, wb_adr_o, wb_dat_o} !== {3'b111, 32'h1000, word_of(16'(D))}) begin
            bad++;
            $display("[TB] FAIL ovf_hold got=%b %h@%h want=111 %h@00001000",
                     {wb_cyc_o, wb_stb_o, busy_o}, wb_dat_o, wb_adr_o, word_of(16'(D)));
        end
        total++;
        if (unstable_cnt != unstable_start) begin
            bad++;
            $display("[TB] FAIL ovf_stable got=%0d changes want=0", unstable_cnt - unstable_start);
        end
        ack_allow = 1'b1;
        tick(12);
        total++;
        if (busy_o !== 1'b0 || obs_q.size() != 5) begin
            bad++;
            $display("[TB] FAIL ovf_drain got=busy %b writes %0d want=busy 0 writes 5", busy_o, obs_q.size());
        end
        enable = 1'b0;
        tick(4);
        total++;
        if (overflow_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_clear got=%b want=0", overflow_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL ovf_missing got=none want=%h@%h", e.dat, e.adr);
            end else begin
                o = obs_q.pop_front();
                if ({o.adr, o.dat} !== {e.adr, e.dat}) begin
                    bad++;
                    $display("[TB] FAIL ovf_write got=%h@%h want=%h@%h", o.dat, o.adr, e.dat, e.adr);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_enable_drop;
        exp_t e;
        obs_t o;
        mic       = 1'b1;
        buf_base  = 32'h0000_1000;
        buf_words = 16'd8;
        ack_allow = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(6 * SPW * D + 2);
        total++;
        if ({wb_stb_o, overflow_o} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL drop_pre got=%b want=11", {wb_stb_o, overflow_o});
        end
        enable = 1'b0;
        tick(3);
        total++;
        if ({wb_cyc_o, overflow_o} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL drop_open got=%b want=10", {wb_cyc_o, overflow_o});
        end
        ack_allow = 1'b1;
        tick(4);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drop_busy got=%b want=0", busy_o);
        end
        tick(3 * D);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("[TB] FAIL drop_writes got=%0d want=1", obs_q.size());
        end
        expect_writes(32'h1000, 1, 0, 8, word_of(16'(D)));
        // Re-enable: the flush reset the offset, so writing restarts at the base
        expect_writes(32'h1000, 1, 0, 8, word_of(16'(D)));
        enable = 1'b1;
        tick(SPW * D + 4);
        enable = 1'b0;
        tick(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL drop_missing got=none want=%h@%h", e.dat, e.adr);
            end else begin
                o = obs_q.pop_front();
                if ({o.adr, o.dat} !== {e.adr, e.dat}) begin
                    bad++;
                    $display("[TB] FAIL drop_write got=%h@%h want=%h@%h", o.dat, o.adr, e.dat, e.adr);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        mic       = 1'b1;
        ack_allow = 1'b0;
        enable    = 1'b1;
        tick(SPW * D + 2);
        total++;
        if (wb_cyc_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid_open got=%b want=1", wb_cyc_o);
        end
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({wb_cyc_o, wb_stb_o, busy_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL rst_mid_drop got=%b want=000", {wb_cyc_o, wb_stb_o, busy_o});
        end
        tick(2);
        enable = 1'b0;
        reset_n = 1'b1;
        ack_allow = 1'b1;
        tick(4);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL rst_mid_writes got=%0d want=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        mic       = 1'b0;
        enable    = 1'b0;
        buf_base  = 32'h0000_1000;
        buf_words = 16'd8;
        ack_allow = 1'b1;
        $display("[TB] wb_mic_dma bench, DIV=%0d FIFO_DEPTH=%0d samples/word=%0d", D, DEPTH, SPW);
        test_reset();
        test_mic_high();
        test_patterns();
        test_wrap();
        test_overflow();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
